gray_codec_pipe: RTL and testbench
==================================

// Module: gray_codec_pipe
// PURPOSE
//   Parametrised, pipelined binary<->Gray converter; next generation of the fixed 4-bit registered encoder.
//   Per-word mode selects encode (bin->gray) or decode (gray->bin); decode prefix-XOR chain split across stages.
//   valid/ready handshake on both sides with full backpressure; sits between counter/pointer logic and CDC paths.
//   Wrapping transfer counter included for debug/throughput checks.
// PARAMETERS
//   WIDTH        8   data width in bits, 2..32
//   PIPE_STAGES  2   pipeline depth = fixed latency in cycles, 1..4; decode chain split into PIPE_STAGES slices
//   CNT_WIDTH    16  width of out_count
// PORTS
//   clk        in   1          single clock; all state updates on rising edge
//   rst_n      in   1          reset, asynchronous assert, active-low
//   in_valid   in   1          input word valid
//   in_ready   out  1          block can accept input this cycle
//   in_mode    in   1          0 = encode bin->gray, 1 = decode gray->bin; sampled with in_data
//   in_data    in   WIDTH      input word
//   out_valid  out  1          output word valid
//   out_ready  in   1          downstream accepts output
//   out_mode   out  1          mode the output word was converted with
//   out_data   out  WIDTH      converted word
//   out_count  out  CNT_WIDTH  number of output transfers (out_valid&&out_ready) since reset, wraps
// BEHAVIOUR
//   Reset: rst_n low clears asynchronously all stage valid bits, out_valid=0, out_mode=0, out_data=0, out_count=0.
//     in_ready=1 from the first cycle after rst_n deasserts. Reset mid-operation discards every in-flight word.
//   Arithmetic: encode g[i]=b[i]^b[i+1], g[MSB]=b[MSB]. Decode b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
//     Decode: stage k resolves bits from MSB downward for its slice of ceil(WIDTH/PIPE_STAGES) bits,
//     carrying partial result, remaining gray bits and the running XOR into next stage.
//     Encode: result formed in stage 1, carried unchanged through remaining stages (equal latency both modes).
//   Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
//     Global advance en = !out_valid || out_ready; in_ready = en (combinational, no dependence on in_valid).
//     en=1: every stage shifts one step; stage 1 loads in_data/in_mode if in_valid, else becomes bubble.
//     en=0: all stages hold; out_data/out_mode stable while out_valid=1 and out_ready=0.
//   Latency: word accepted at edge N presents out_valid=1 after edge N+PIPE_STAGES-1 if not stalled.
//   Throughput: one word per cycle when out_ready held high; order preserved; no word dropped or duplicated.
//   Simultaneous: output transfer and input transfer in same cycle both complete (pipeline full-rate).
//   Bubbles: gaps in in_valid propagate as out_valid=0 cycles; bubbles do not stall the pipe.
//   Mode switching: each word uses its own sampled in_mode; mixed-mode streams back-to-back are legal.
//   out_count increments by 1 per output transfer, wraps 2^CNT_WIDTH-1 -> 0, no saturation flag.
//   in_mode/in_data ignored when in_valid=0; X on them then must not reach outputs.
// TESTING (WIDTH=4, PIPE_STAGES=2 unless stated)
//   1 Reset: rst_n=0 mid-stream with 2 words in flight -> out_valid=0, out_count=0 immediately; in_ready=1 after release.
//   2 Encode sweep 0..15, out_ready=1 -> 1010->1111, 1111->1000, 0101->0111; one result/cycle, latency 2.
//   3 Decode sweep all 16 gray codes -> 1111->1010, 1000->1111, 0111->0101; round-trip encode->decode = identity.
//   4 Backpressure: out_ready=0 for 5 cycles with full pipe -> in_ready=0, out_data held, no loss; resume in order.
//   5 Mixed modes back-to-back: enc 0011, dec 0011, enc 1100 -> 0010, 0010, 1010 with matching out_mode 0,1,0.
//   6 Params: WIDTH=13, PIPE_STAGES=4 and 1, random data/mode/ready vs ref model; CNT_WIDTH=4 wraps 15->0.

Source files
------------

// File: rtl/gray_codec_if.sv
// ============================================================================
//  Module      : gray_codec_if
//  Description : Input/output valid-ready bus for the pipelined Gray codec.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface gray_codec_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_mode;
    logic [WIDTH-1:0]     out_data;
    logic [CNT_WIDTH-1:0] out_count;

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_count
    );

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_count
    );
endinterface

`default_nettype wire

// File: rtl/gray_codec_pipe.sv
// ============================================================================
//  Module      : gray_codec_pipe
//  Description : Pipelined binary<->Gray converter, per-word mode, valid/ready
//                with full backpressure and a wrapping output-transfer count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gray_codec_pipe #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    gray_codec_if.slave bus
);

    localparam int SLICE = (WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;

    logic                 adv;
    logic [CNT_WIDTH-1:0] cnt_q;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        localparam int  HI    = WIDTH - 1 - k * SLICE;
        localparam int  LO    = WIDTH - (k + 1) * SLICE;
        localparam int  CI    = (HI + 1 < 0) ? 0 : HI + 1;
        localparam bit  FIRST = (k == 0);

        logic             src_valid;
        logic             src_mode;
        logic             src_xor;
        logic [WIDTH-1:0] src_data;
        logic [WIDTH-1:0] data_d;
        logic             run;
        logic             valid_q;
        logic             mode_q;
        logic [WIDTH-1:0] data_q;

        if (k == 0) begin : g_head
            // Bubbles load zeros so idle X on the inputs never propagates.
            assign src_valid = bus.in_valid;
            assign src_mode  = bus.in_valid & bus.in_mode;
            assign src_data  = bus.in_valid ? bus.in_data : '0;
            assign src_xor   = 1'b0;
        end else begin : g_body
            // The running XOR is the lowest bit already resolved upstream.
            assign src_valid = g_stage[k-1].valid_q;
            assign src_mode  = g_stage[k-1].mode_q;
            assign src_data  = g_stage[k-1].data_q;
            assign src_xor   = g_stage[k-1].data_q[CI];
        end

        always_comb begin
            run    = src_xor;
            data_d = src_data;
            if (src_mode) begin
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (i <= HI && i >= LO) begin
                        run       = run ^ src_data[i];
                        data_d[i] = run;
                    end
                end
            end else if (FIRST) begin
                data_d = src_data ^ (src_data >> 1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                mode_q  <= 1'b0;
                data_q  <= '0;
            end else if (adv) begin
                valid_q <= src_valid;
                mode_q  <= src_mode;
                data_q  <= data_d;
            end
        end
    end

    assign adv           = !g_stage[PIPE_STAGES-1].valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = g_stage[PIPE_STAGES-1].valid_q;
    assign bus.out_mode  = g_stage[PIPE_STAGES-1].mode_q;
    assign bus.out_data  = g_stage[PIPE_STAGES-1].data_q;
    assign bus.out_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gray_codec_pipe.sv
// ============================================================================
//  Module      : tb_gray_codec_pipe
//  Description : Directed and randomised self-checking bench for gray_codec_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gray_codec_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gray_codec_if #(.WIDTH(4),  .CNT_WIDTH(16)) bus_a ();
    gray_codec_if #(.WIDTH(13), .CNT_WIDTH(4))  bus_b ();
    gray_codec_if #(.WIDTH(13), .CNT_WIDTH(8))  bus_c ();

    gray_codec_pipe #(.WIDTH(4),  .PIPE_STAGES(2), .CNT_WIDTH(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    gray_codec_pipe #(.WIDTH(13), .PIPE_STAGES(4), .CNT_WIDTH(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    gray_codec_pipe #(.WIDTH(13), .PIPE_STAGES(1), .CNT_WIDTH(8))  dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [4:0] got_q [$];

    always @(negedge clk)
        if (rst_n && bus_a.out_valid && bus_a.out_ready)
            got_q.push_back({bus_a.out_mode, bus_a.out_data});

    function automatic logic [12:0] ref_conv(input logic m, input logic [12:0] x);
        logic [12:0] r;
        if (!m) return x ^ (x >> 1);
        r[12] = x[12];
        for (int i = 11; i >= 0; i--) r[i] = r[i+1] ^ x[i];
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.in_valid = 1'b0; bus_a.in_mode = 1'bx; bus_a.in_data = 'x;
        bus_b.in_valid = 1'b0; bus_b.in_mode = 1'bx; bus_b.in_data = 'x;
        bus_c.in_valid = 1'b0; bus_c.in_mode = 1'bx; bus_c.in_data = 'x;
    endtask

    task automatic test_reset();
        logic [3:0] words [3];
        words = '{4'b0001, 4'b0010, 4'b0100};
        rst_n = 1'b0;
        idle_all();
        bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1; bus_c.out_ready = 1'b1;
        #2;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus_a.out_valid); end
        checks++; if (bus_a.out_count !== 16'd0) begin errors++; $display("FAIL rst_out_count got %0d exp 0", bus_a.out_count); end
        checks++; if ({bus_a.out_mode, bus_a.out_data} !== 5'd0) begin errors++; $display("FAIL rst_out_word got %h exp 00", {bus_a.out_mode, bus_a.out_data}); end
        cycle();
        rst_n = 1'b1;
        cycle();
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus_a.in_ready); end
        for (int i = 0; i < 3; i++) begin
            bus_a.in_valid = 1'b1; bus_a.in_mode = 1'b0; bus_a.in_data = words[i];
            cycle();
        end
        checks++; if (bus_a.out_count !== 16'd1) begin errors++; $display("FAIL pre_rst_count got %0d exp 1", bus_a.out_count); end
        idle_all();
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus_a.out_valid); end
        checks++; if (bus_a.out_count !== 16'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", bus_a.out_count); end
        cycle();
        rst_n = 1'b1;
        cycle();
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", bus_a.in_ready); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL flushed_valid[%0d] got %b exp 0", i, bus_a.out_valid); end
        end
        got_q.delete();
    endtask

    task automatic test_sweep(input logic mode);
        logic [3:0] e;
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_mode  = mode;
            bus_a.in_data  = mode ? gray_tbl[i] : 4'(i);
            cycle();
            if (i == 0) begin
                checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL sweep%0d_latency got valid %b exp 0", mode, bus_a.out_valid); end
            end else begin
                e = mode ? 4'(i - 1) : gray_tbl[i-1];
                checks++;
                if ({bus_a.out_valid, bus_a.out_mode, bus_a.out_data} !== {1'b1, mode, e}) begin
                    errors++;
                    $display("FAIL sweep%0d[%0d] got v%b m%b %b exp v1 m%b %b", mode, i - 1,
                             bus_a.out_valid, bus_a.out_mode, bus_a.out_data, mode, e);
                end
            end
        end
        idle_all();
        cycle();
        e = mode ? 4'd15 : gray_tbl[15];
        checks++; if ({bus_a.out_valid, bus_a.out_data} !== {1'b1, e}) begin errors++; $display("FAIL sweep%0d[15] got v%b %b exp v1 %b", mode, bus_a.out_valid, bus_a.out_data, e); end
        cycle();
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL sweep%0d_drain got %b exp 0", mode, bus_a.out_valid); end
        checks++; if (bus_a.out_count !== (mode ? 16'd32 : 16'd16)) begin errors++; $display("FAIL sweep%0d_count got %0d exp %0d", mode, bus_a.out_count, mode ? 32 : 16); end
        got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [3:0] din [4];
        logic [3:0] dexp [4];
        din  = '{4'b0011, 4'b0110, 4'b1001, 4'b1110};
        dexp = '{4'b0010, 4'b0101, 4'b1101, 4'b1001};
        got_q.delete();
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_mode = 1'b0; bus_a.in_data = din[0];
        cycle();
        bus_a.in_data = din[1];
        cycle();
        bus_a.in_data = din[2];
        #1;
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", bus_a.in_ready); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if ({bus_a.in_ready, bus_a.out_valid, bus_a.out_data} !== {1'b0, 1'b1, dexp[0]}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got rdy%b v%b %b exp rdy0 v1 %b", i,
                         bus_a.in_ready, bus_a.out_valid, bus_a.out_data, dexp[0]);
            end
        end
        bus_a.out_ready = 1'b1;
        #1;
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", bus_a.in_ready); end
        cycle();
        bus_a.in_data = din[3];
        cycle();
        idle_all();
        repeat (3) cycle();
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL bp_count_words got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== {1'b0, dexp[i]}) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", i, got_q[i], {1'b0, dexp[i]}); end
        end
        checks++; if (bus_a.out_count !== 16'd36) begin errors++; $display("FAIL bp_out_count got %0d exp 36", bus_a.out_count); end
    endtask

    task automatic test_mixed();
        logic [4:0] din [3];
        logic [4:0] dexp [3];
        din  = '{5'b0_0011, 5'b1_0011, 5'b0_1100};
        dexp = '{5'b0_0010, 5'b1_0010, 5'b0_1010};
        got_q.delete();
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.in_valid = 1'b1; {bus_a.in_mode, bus_a.in_data} = din[i];
            cycle();
        end
        idle_all();
        repeat (3) cycle();
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL mixed_words got %0d exp 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== dexp[i]) begin errors++; $display("FAIL mixed[%0d] got %b exp %b", i, got_q[i], dexp[i]); end
        end
        checks++; if (bus_a.out_count !== 16'd39) begin errors++; $display("FAIL mixed_out_count got %0d exp 39", bus_a.out_count); end
    endtask

    task automatic test_params();
        logic [13:0] qb [$];
        logic [13:0] qc [$];
        logic [13:0] e;
        logic [12:0] d;
        logic        m, v, r;
        logic [3:0]  pb;
        int          nb = 0, nc = 0;
        bit          wrap_seen = 1'b0;
        for (int t = 0; t < 320; t++) begin
            v = (t < 300) && ($urandom_range(0, 3) != 0);
            r = (t >= 300) || ($urandom_range(0, 3) != 0);
            m = 1'($urandom);
            d = 13'($urandom);
            bus_b.out_ready = r; bus_c.out_ready = r;
            bus_b.in_valid = v;  bus_c.in_valid = v;
            bus_b.in_mode = v ? m : 1'bx; bus_c.in_mode = v ? m : 1'bx;
            bus_b.in_data = v ? d : 'x;   bus_c.in_data = v ? d : 'x;
            #1;
            if (bus_b.in_valid && bus_b.in_ready) qb.push_back({m, ref_conv(m, d)});
            if (bus_c.in_valid && bus_c.in_ready) qc.push_back({m, ref_conv(m, d)});
            if (bus_b.out_valid && bus_b.out_ready) begin
                e = (qb.size() > 0) ? qb.pop_front() : 'x;
                nb++;
                checks++; if ({bus_b.out_mode, bus_b.out_data} !== e) begin errors++; $display("FAIL p4_word[%0d] got %h exp %h", nb, {bus_b.out_mode, bus_b.out_data}, e); end
            end
            if (bus_c.out_valid && bus_c.out_ready) begin
                e = (qc.size() > 0) ? qc.pop_front() : 'x;
                nc++;
                checks++; if ({bus_c.out_mode, bus_c.out_data} !== e) begin errors++; $display("FAIL p1_word[%0d] got %h exp %h", nc, {bus_c.out_mode, bus_c.out_data}, e); end
            end
            pb = bus_b.out_count;
            cycle();
            if (pb == 4'hF && bus_b.out_count == 4'h0) wrap_seen = 1'b1;
        end
        idle_all();
        checks++; if (qb.size() != 0 || qc.size() != 0) begin errors++; $display("FAIL param_drain got %0d/%0d pending exp 0/0", qb.size(), qc.size()); end
        checks++; if (bus_b.out_count !== 4'(nb)) begin errors++; $display("FAIL p4_count got %0d exp %0d", bus_b.out_count, 4'(nb)); end
        checks++; if (bus_c.out_count !== 8'(nc)) begin errors++; $display("FAIL p1_count got %0d exp %0d", bus_c.out_count, 8'(nc)); end
        checks++; if (!wrap_seen || nb <= 16) begin errors++; $display("FAIL p4_wrap got seen=%0d n=%0d exp seen=1 n>16", wrap_seen, nb); end
    endtask

    initial begin
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_backpressure();
        test_mixed();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
